mmio_port_responder: RTL and testbench
======================================

// Module: mmio_port_responder
// PURPOSE
//   Memory-mapped I/O responder on the processor's data-memory bus. It is the target end of the
//   load/store interface that the core drives (Address = ALU result, WriteData = rt, MemRead/MemWrite).
//   - Owns the 32-bit PortOut register.
//   - Synchronises the 8-bit PortIn and records every input change in a small FIFO.
//   - Asserts Hit so the top level steers ReadData between DataMemory and this block.
// PARAMETERS
//   BASE_ADDR    32'h1001_0000  word-aligned base of the 5-word register window
//   FIFO_DEPTH   4              PortIn change-FIFO entries; power of two, >=2
//   SYNC_STAGES  2              PortIn synchroniser flops; >=2
// PORTS
//   clk        in   1   single clock; all state updates on rising edge
//   reset      in   1   synchronous, active-high
//   Address    in   32  byte address from the core; bits [1:0] ignored
//   WriteData  in   32  store data
//   MemWrite   in   1   store strobe, sampled at clk edge
//   MemRead    in   1   load strobe
//   PortIn     in   8   asynchronous external input
//   ReadData   out  32  load data, combinational
//   Hit        out  1   Address[31:2] falls inside the window, combinational, strobe-independent
//   PortOut    out  32  registered output port
//   Irq        out  1   present only with MMIO_IRQ_EN
// BEHAVIOUR
//   Map (offset from BASE_ADDR):
//     0x00 PORT_OUT   R/W
//     0x04 PORT_IN    R    {24'b0, synced PortIn}
//     0x08 STATUS     R/W1C; details below
//     0x0C FIFO_DATA  R    pops the FIFO
//     0x10 CTRL       R/W
//   Writes to read-only offsets are ignored.
//   ReadData = selected register when MemRead & Hit, else 32'h0. Pure function of current state, zero latency.
//   Writes take effect on the clk edge where MemWrite & Hit. PortOut changes on that same edge.
//   Synchroniser and change detection:
//     - sync chain of SYNC_STAGES flops; prev <= sync every cycle.
//     - change = (sync != prev). A change pushes sync into the FIFO.
//     - PortIn edge -> FIFO entry visible after SYNC_STAGES+1 edges.
//   STATUS fields:
//     - [0] not_empty, [1] full, [2] overflow (sticky), [15:8] count (0..FIFO_DEPTH). Other bits read 0.
//     - Writing 1 to bit 2 clears overflow. Other STATUS bits ignore writes.
//   FIFO_DATA read:
//     - Returns {24'b0, head}. If the FIFO is not empty, it pops on that edge.
//     - A read while empty returns 0; no pointer change.
//   FIFO boundaries:
//     - Push while full (and no pop): entry dropped, overflow set, contents unchanged.
//     - Push + pop same edge, full: both occur, count unchanged, no overflow.
//     - Push + pop same edge, empty: read returns 0, pop ignored, push stored (count=1).
//     - Pointers wrap modulo FIFO_DEPTH.
//   Overflow set and W1C clear on the same edge: set wins.
//   Reset: PortOut=0, sync/prev=0, FIFO empty (count 0), overflow=0, CTRL=0, Irq=0.
//     Reset asserted mid-operation discards FIFO contents on that edge.
//     A nonzero PortIn held through reset is logged as a change SYNC_STAGES+1 edges after release.
// CONFIGURATION
//   MMIO_IRQ_EN defined:
//     - CTRL[0] = irq_enable, R/W; CTRL[31:1] read 0.
//     - Irq is registered: Irq <= irq_enable & (not_empty | overflow), one edge after the condition.
//   MMIO_IRQ_EN undefined:
//     - No Irq port. CTRL reads 0 and ignores writes; CTRL offset still asserts Hit.
// TESTING
//   1. Reset, then store 32'hDEAD_BEEF to BASE+0x00 -> PortOut=DEAD_BEEF on that edge; load BASE+0x00 returns DEAD_BEEF.
//   2. PortIn 0->8'h5A at edge n -> STATUS=0x0000_0101 after edge n+3; FIFO_DATA load returns 0x5A, then STATUS=0.
//   3. Five changes with FIFO_DEPTH=4, no reads -> STATUS=0x0000_0407 (count 4, full, overflow).
//      Then write 0x4 to STATUS -> overflow clear, STATUS=0x0000_0403.
//   4. FIFO full, a PortIn change coincides with a FIFO_DATA read -> count stays 4, overflow stays 0, oldest entry returned.
//   5. FIFO_DATA read while empty -> 0, count 0. Address BASE+0x14 -> Hit=0 and ReadData=0 with MemRead=1.
//   6. MMIO_IRQ_EN: CTRL=1, push one entry -> Irq=1 next edge; pop it -> Irq=0 the edge after; reset -> Irq=0.

Source files
------------

// File: rtl/mmio_port_responder.sv
// mmio_port_responder
// Memory-mapped I/O target on the core's data-memory bus. It owns the PortOut
// register, synchronises the external PortIn byte and logs every change of the
// synchronised value in a small FIFO with a sticky overflow flag.
// Optional feature macro: MMIO_IRQ_EN (adds CTRL.irq_enable and the Irq port).
//
// Bus semantics: there is no handshake and the block never stalls the core.
// Hit is a pure address decode, independent of the strobes. A load
// (MemRead & Hit) returns data combinationally in the same cycle. A store
// (MemWrite & Hit) and a FIFO pop caused by a FIFO_DATA load commit on the
// next rising clk edge.
//
// Register window (word offsets from BASE_ADDR):
//   0x00 PORT_OUT  R/W
//   0x04 PORT_IN   R    {24'b0, synchronised PortIn}
//   0x08 STATUS    R/W1C {16'b0, count[7:0], 5'b0, overflow, full, not_empty}
//   0x0C FIFO_DATA R    {24'b0, head}; pops when the FIFO is not empty
//   0x10 CTRL      R/W  bit 0 irq_enable (only with MMIO_IRQ_EN, else reads 0)

module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut
`ifdef MMIO_IRQ_EN
    ,
    output logic        Irq
`endif
);

    // FIFO pointer and occupancy widths; the count needs one extra bit so
    // that a full FIFO (count == FIFO_DEPTH) is distinguishable from empty.
    localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [29:0]   BASE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0]   WIN_WORDS = 30'd5;

    localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFF_PORT_IN   = 3'd1;
    localparam logic [2:0] OFF_STATUS    = 3'd2;
    localparam logic [2:0] OFF_FIFO_DATA = 3'd3;
    localparam logic [2:0] OFF_CTRL      = 3'd4;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0] word_off;
    logic [2:0]  reg_sel;
    logic        unused_addr_bits;
    logic        rd_en;
    logic        wr_en;
    logic        wr_port_out;
    logic        wr_status;
    logic        rd_fifo;

    // Unsigned subtraction: addresses below the base wrap to a large offset
    // and therefore fall outside the window as well.
    assign word_off         = Address[31:2] - BASE_WORD;
    assign Hit              = (word_off < WIN_WORDS);
    assign reg_sel          = word_off[2:0];
    assign unused_addr_bits = ^Address[1:0];

    assign rd_en       = MemRead & Hit;
    assign wr_en       = MemWrite & Hit;
    assign wr_port_out = wr_en && (reg_sel == OFF_PORT_OUT);
    assign wr_status   = wr_en && (reg_sel == OFF_STATUS);
    assign rd_fifo     = rd_en && (reg_sel == OFF_FIFO_DATA);

    // ------------------------------------------------------------------
    // PortOut register
    // ------------------------------------------------------------------
    // Store to PORT_OUT updates the output port on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut <= 32'h0;
        end else if (wr_port_out) begin
            PortOut <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // PortIn synchroniser and change detection
    // ------------------------------------------------------------------
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] prev_q;
    logic [7:0] port_sync;
    logic       change;

    assign port_sync = sync_q[SYNC_STAGES-1];
    assign change    = (port_sync != prev_q);

    // Synchroniser chain plus the previous synchronised value used to spot
    // changes; clearing both on reset makes a nonzero PortIn held through
    // reset show up as a change once it has crossed the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
            prev_q <= 8'h00;
        end else begin
            sync_q[0] <= PortIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= port_sync;
        end
    end

    // ------------------------------------------------------------------
    // Change FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;
    logic [7:0]    fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // A pop on an empty FIFO is ignored. A push into a full FIFO only
    // succeeds when a pop frees the head slot on the same edge; otherwise the
    // entry is dropped and overflow is flagged.
    assign pop     = rd_fifo & ~fifo_empty;
    assign push    = change & (~fifo_full | pop);
    assign ovf_set = change & fifo_full & ~pop;
    assign ovf_clr = wr_status & WriteData[2];

    // Storage array: data only, validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr_q] <= port_sync;
        end
    end

    // Pointers, occupancy and sticky overflow; a new overflow beats a
    // W1C clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // CTRL register and interrupt
    // ------------------------------------------------------------------
    logic [31:0] ctrl_value;

`ifdef MMIO_IRQ_EN
    logic wr_ctrl;
    logic irq_enable_q;

    assign wr_ctrl    = wr_en && (reg_sel == OFF_CTRL);
    assign ctrl_value = {31'h0, irq_enable_q};

    // irq_enable register and the registered interrupt, raised one edge
    // after the FIFO holds data or overflow is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_enable_q <= 1'b0;
            Irq          <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_enable_q <= WriteData[0];
            end
            Irq <= irq_enable_q & (~fifo_empty | ovf_q);
        end
    end
`else
    assign ctrl_value = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] status_value;
    logic [31:0] fifo_value;

    assign status_value = {16'h0, 8'(count_q), 5'h0, ovf_q, fifo_full, ~fifo_empty};
    assign fifo_value   = fifo_empty ? 32'h0 : {24'h0, fifo_head};

    // Zero-latency load data; zero whenever no load targets the window.
    always_comb begin
        ReadData = 32'h0;
        if (rd_en) begin
            case (reg_sel)
                OFF_PORT_OUT:  ReadData = PortOut;
                OFF_PORT_IN:   ReadData = {24'h0, port_sync};
                OFF_STATUS:    ReadData = status_value;
                OFF_FIFO_DATA: ReadData = fifo_value;
                OFF_CTRL:      ReadData = ctrl_value;
                default:       ReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder
// Directed/random bench for mmio_port_responder. Expected FIFO entries are
// queued in exp_q when PortIn is changed and popped when FIFO_DATA is read.
// Build with +define+MMIO_IRQ_EN to also exercise CTRL and Irq.

module tb_mmio_port_responder;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] A_OUT  = BASE + 32'h00;
    localparam logic [31:0] A_IN   = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam logic [31:0] A_FIFO = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = 8'h00;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
`ifdef MMIO_IRQ_EN
    logic        Irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [7:0]  last_in = 8'h00;
    logic [31:0] exp_port_out = 32'h0;

    mmio_port_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .PortIn   (PortIn),
        .ReadData (ReadData),
        .Hit      (Hit),
        .PortOut  (PortOut)
`ifdef MMIO_IRQ_EN
        ,
        .Irq      (Irq)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Address = a;
        MemRead = 1'b1;
        #1 d = ReadData;
        @(posedge clk);
        #1 MemRead = 1'b0;
    endtask

    // Combinational look at a side-effect-free register without a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        MemRead = 1'b1;
        #1 d = ReadData;
        MemRead = 1'b0;
    endtask

    // Changes PortIn and updates the scoreboard, then lets the change settle.
    task automatic change_port_in(input logic [7:0] v);
        @(negedge clk);
        PortIn = v;
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else exp_ovf = 1'b1;
        last_in = v;
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [7:0] new_val();
        logic [7:0] v;
        v = last_in;
        while (v == last_in) v = 8'($urandom_range(1, 255));
        return v;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [7:0] n;
        n = 8'(exp_q.size());
        return {16'h0, n, 5'h0, exp_ovf, (exp_q.size() == DEPTH), (exp_q.size() != 0)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        PortIn = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (PortOut !== 32'h0) begin
            errors++; $display("FAIL reset_port_out: got %h expected %h", PortOut, 32'h0);
        end
        reset = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0; last_in = 8'h00; exp_port_out = 32'h0;
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h0);
        end
        bus_read(A_IN, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_port_in: got %h expected %h", rd, 32'h0);
        end
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_port_out();
        logic [31:0] rd;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            @(negedge clk);
            Address = A_OUT; WriteData = d; MemWrite = 1'b1;
            #1;
            checks++;
            if (PortOut !== exp_port_out) begin
                errors++; $display("FAIL port_out_before_edge: got %h expected %h", PortOut, exp_port_out);
            end
            @(posedge clk);
            #1 MemWrite = 1'b0;
            exp_port_out = d;
            checks++;
            if (PortOut !== d) begin
                errors++; $display("FAIL port_out_same_edge: got %h expected %h", PortOut, d);
            end
            bus_read(A_OUT, rd);
            checks++;
            if (rd !== d) begin
                errors++; $display("FAIL port_out_readback: got %h expected %h", rd, d);
            end
        end
        // Read-only offsets ignore stores.
        bus_write(A_IN, 32'hFFFF_FFFF);
        bus_write(A_FIFO, 32'hFFFF_FFFF);
        bus_read(A_IN, rd);
        checks++;
        if (rd !== {24'h0, last_in}) begin
            errors++; $display("FAIL ro_port_in: got %h expected %h", rd, {24'h0, last_in});
        end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL ro_status: got %h expected %h", rd, exp_status());
        end
        checks++;
        if (PortOut !== exp_port_out) begin
            errors++; $display("FAIL ro_port_out: got %h expected %h", PortOut, exp_port_out);
        end
    endtask

    task automatic test_port_in_fifo();
        logic [31:0] rd;
        logic [7:0]  e;
        @(negedge clk);
        PortIn = 8'h5A;
        exp_q.push_back(8'h5A);
        last_in = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        peek(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL sync_latency_early: got %h expected %h", rd, 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        peek(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0101) begin
            errors++; $display("FAIL sync_latency_status: got %h expected %h", rd, 32'h0000_0101);
        end
        bus_read(A_IN, rd);
        checks++;
        if (rd !== 32'h0000_005A) begin
            errors++; $display("FAIL port_in_read: got %h expected %h", rd, 32'h0000_005A);
        end
        bus_read(A_FIFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL fifo_first_pop: got %h expected %h", rd, {24'h0, e});
        end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL status_after_pop: got %h expected %h", rd, 32'h0);
        end
        // A few random changes drained in order.
        for (int i = 0; i < 3; i++) change_port_in(new_val());
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL status_three: got %h expected %h", rd, exp_status());
        end
        while (exp_q.size() > 0) begin
            bus_read(A_FIFO, rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== {24'h0, e}) begin
                errors++; $display("FAIL fifo_drain: got %h expected %h", rd, {24'h0, e});
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  v;
        for (int i = 0; i < 5; i++) change_port_in(new_val());
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0407) begin
            errors++; $display("FAIL overflow_status: got %h expected %h", rd, 32'h0000_0407);
        end
        bus_write(A_STAT, 32'h0000_0004);
        exp_ovf = 1'b0;
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0403) begin
            errors++; $display("FAIL overflow_w1c: got %h expected %h", rd, 32'h0000_0403);
        end
        // Overflow set and W1C clear on the same edge: set wins.
        v = new_val();
        @(negedge clk);
        PortIn = v;
        last_in = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Address = A_STAT; WriteData = 32'h0000_0004; MemWrite = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
        exp_ovf = 1'b1;
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL overflow_set_wins: got %h expected %h", rd, exp_status());
        end
        // Writing 0 to bit 2 leaves overflow alone; other bits ignore writes.
        bus_write(A_STAT, 32'hFFFF_FFFB);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL status_ignore_bits: got %h expected %h", rd, exp_status());
        end
        bus_write(A_STAT, 32'h0000_0004);
        exp_ovf = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  e;
        v = new_val();
        @(negedge clk);
        PortIn = v;
        last_in = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Address = A_FIFO; MemRead = 1'b1;
        #1 rd = ReadData;
        e = exp_q.pop_front();
        exp_q.push_back(v);
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL full_push_pop_data: got %h expected %h", rd, {24'h0, e});
        end
        @(posedge clk);
        #1 MemRead = 1'b0;
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0403) begin
            errors++; $display("FAIL full_push_pop_status: got %h expected %h", rd, 32'h0000_0403);
        end
        while (exp_q.size() > 0) begin
            bus_read(A_FIFO, rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== {24'h0, e}) begin
                errors++; $display("FAIL full_drain: got %h expected %h", rd, {24'h0, e});
            end
        end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL full_drain_status: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_empty_and_miss();
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  e;
        bus_read(A_FIFO, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL empty_read: got %h expected %h", rd, 32'h0);
        end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL empty_read_count: got %h expected %h", rd, 32'h0);
        end
        @(negedge clk);
        Address = BASE + 32'h14; MemRead = 1'b1;
        #1;
        checks++;
        if (Hit !== 1'b0) begin
            errors++; $display("FAIL miss_hit_above: got %b expected %b", Hit, 1'b0);
        end
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("FAIL miss_read_data: got %h expected %h", ReadData, 32'h0);
        end
        Address = BASE - 32'h4;
        #1;
        checks++;
        if (Hit !== 1'b0) begin
            errors++; $display("FAIL miss_hit_below: got %b expected %b", Hit, 1'b0);
        end
        MemRead = 1'b0;
        Address = A_CTRL;
        #1;
        checks++;
        if (Hit !== 1'b1) begin
            errors++; $display("FAIL hit_ctrl_no_strobe: got %b expected %b", Hit, 1'b1);
        end
        Address = A_OUT;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("FAIL read_data_no_strobe: got %h expected %h", ReadData, 32'h0);
        end
        Address = A_OUT | 32'h3; MemRead = 1'b1;
        #1;
        checks++;
        if (ReadData !== exp_port_out) begin
            errors++; $display("FAIL byte_bits_ignored: got %h expected %h", ReadData, exp_port_out);
        end
        MemRead = 1'b0;
        // Push and pop on the same edge while empty: pop ignored, push kept.
        v = new_val();
        @(negedge clk);
        PortIn = v;
        last_in = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Address = A_FIFO; MemRead = 1'b1;
        #1 rd = ReadData;
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL empty_push_pop_data: got %h expected %h", rd, 32'h0);
        end
        @(posedge clk);
        #1 MemRead = 1'b0;
        exp_q.push_back(v);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0101) begin
            errors++; $display("FAIL empty_push_pop_status: got %h expected %h", rd, 32'h0000_0101);
        end
        bus_read(A_FIFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL empty_push_pop_entry: got %h expected %h", rd, {24'h0, e});
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] rd;
        logic [31:0] exp_ctrl;
`ifdef MMIO_IRQ_EN
        exp_ctrl = 32'h1;
`else
        exp_ctrl = 32'h0;
`endif
        bus_write(A_CTRL, 32'hFFFF_FFFF);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== exp_ctrl) begin
            errors++; $display("FAIL ctrl_readback: got %h expected %h", rd, exp_ctrl);
        end
        bus_write(A_CTRL, 32'h0);
    endtask

`ifdef MMIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  e;
        bus_write(A_CTRL, 32'h1);
        @(negedge clk);
        checks++;
        if (Irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got %b expected %b", Irq, 1'b0);
        end
        v = new_val();
        PortIn = v;
        last_in = v;
        exp_q.push_back(v);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (Irq !== 1'b0) begin
            errors++; $display("FAIL irq_push_edge: got %b expected %b", Irq, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Irq !== 1'b1) begin
            errors++; $display("FAIL irq_raise: got %b expected %b", Irq, 1'b1);
        end
        bus_read(A_FIFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL irq_pop_data: got %h expected %h", rd, {24'h0, e});
        end
        @(negedge clk);
        checks++;
        if (Irq !== 1'b1) begin
            errors++; $display("FAIL irq_pop_edge: got %b expected %b", Irq, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall: got %b expected %b", Irq, 1'b0);
        end
        change_port_in(new_val());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Irq !== 1'b0) begin
            errors++; $display("FAIL irq_reset: got %b expected %b", Irq, 1'b0);
        end
        reset = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0; exp_port_out = 32'h0;
        exp_q.push_back(last_in);
        repeat (4) @(posedge clk);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL irq_ctrl_after_reset: got %h expected %h", rd, 32'h0);
        end
        bus_read(A_FIFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL irq_held_input: got %h expected %h", rd, {24'h0, e});
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  e;
        bus_write(A_OUT, 32'h1234_5678);
        exp_port_out = 32'h1234_5678;
        change_port_in(new_val());
        change_port_in(new_val());
        v = new_val();
        @(negedge clk);
        PortIn = v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (PortOut !== 32'h0) begin
            errors++; $display("FAIL mid_reset_port_out: got %h expected %h", PortOut, 32'h0);
        end
        peek(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL mid_reset_status: got %h expected %h", rd, 32'h0);
        end
        reset = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0; exp_port_out = 32'h0;
        last_in = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        peek(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL release_early: got %h expected %h", rd, 32'h0);
        end
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        peek(A_STAT, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL release_logged: got %h expected %h", rd, exp_status());
        end
        bus_read(A_FIFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== {24'h0, e}) begin
            errors++; $display("FAIL release_entry: got %h expected %h", rd, {24'h0, e});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_port_out();
        test_port_in_fifo();
        test_overflow();
        test_full_push_pop();
        test_empty_and_miss();
        test_ctrl();
`ifdef MMIO_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
